carregador_programa: RTL and testbench
======================================

Name: carregador_programa

Overview:
Boot loader upstream of the nRisc core and its instruction memory. It receives a program as an 8-bit valid/ready byte stream and writes it into the instruction memory starting at address 0. It verifies a trailing checksum, then releases the core from reset. It holds the core in reset for the whole load and after any checksum error.

Parameters:
LARGURA_DADO, 8, width of stream bytes and instruction words
LARGURA_END, 8, instruction memory address width (256 entries, matches the 8-bit PC)

Ports:
Clock  input  1  single system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Iniciar  input  1  start/restart load request, sampled on the rising edge
EntradaValida  input  1  stream byte valid
EntradaDado  input  LARGURA_DADO  stream byte
EntradaPronta  output  1  loader accepts a byte this cycle
EscritaMemInst  output  1  instruction memory write strobe
EndMemInst  output  LARGURA_END  instruction memory write address
DadoMemInst  output  LARGURA_DADO  instruction memory write data
ResetProcessador  output  1  holds nRisc (PC and registers) in reset
Carregando  output  1  load in progress
Concluido  output  1  program loaded, checksum good, core running
ErroChecksum  output  1  last load failed checksum

Behaviour:
- Reset is asynchronous, active-high. While Reset is asserted and after it deasserts:
  - state = OCIOSO
  - EntradaPronta, EscritaMemInst, Carregando, Concluido, ErroChecksum = 0
  - EndMemInst = 0, DadoMemInst = 0
  - ResetProcessador = 1
  - internal counter and sum = 0
- Transfer: one byte is accepted on a rising edge where EntradaValida=1 and EntradaPronta=1. The source may deassert valid at any time. One byte per cycle at maximum rate, no bubbles.
- Frame format:
  - header byte H, giving H+1 payload bytes (1..256)
  - the payload bytes
  - checksum byte C
  - the frame is valid when (sum of payload + C) mod 256 = 0
- FSM states: OCIOSO, CABECALHO, CARGA, CHECKSUM, EXECUTA, ERRO.
- OCIOSO:
  - EntradaPronta=0, ResetProcessador=1
  - Iniciar=1 -> CABECALHO
  - a valid byte in the same cycle as Iniciar is not accepted
- CABECALHO:
  - EntradaPronta=1, Carregando=1
  - on transfer: restantes<=H, soma<=0, endereco<=0 -> CARGA
- CARGA:
  - EntradaPronta=1, Carregando=1
  - on transfer, on that edge: EscritaMemInst<=1, EndMemInst<=endereco, DadoMemInst<=byte, soma<=soma+byte (mod 256)
  - if restantes=0 -> CHECKSUM; else restantes--, endereco++
  - EscritaMemInst is high for exactly one cycle per accepted byte and 0 otherwise; the memory captures on the following edge
  - latency: handshake edge to strobe visible is 1 cycle
  - endereco never wraps: the maximum frame ends at address 255
- CHECKSUM:
  - EntradaPronta=1, Carregando=1
  - on transfer: (soma+C) mod 256 = 0 -> EXECUTA, else -> ERRO
- EXECUTA:
  - ResetProcessador=0, Concluido=1, EntradaPronta=0
  - Iniciar=1 -> CABECALHO; on that same edge ResetProcessador<=1 and Concluido<=0
- ERRO:
  - ErroChecksum=1, ResetProcessador=1, EntradaPronta=0
  - Iniciar=1 -> CABECALHO, ErroChecksum<=0
- Iniciar is ignored in CABECALHO, CARGA and CHECKSUM.
- All outputs are registered, except EntradaPronta, which is decoded from the state only and never depends on EntradaValida.
- Reset mid-load:
  - return to OCIOSO immediately
  - any pending write strobe is dropped
  - already-written memory words are not cleared
  - ResetProcessador=1

Decomposition:
- Shared package nrisc_pkg:
  - LARGURA_DADO and LARGURA_END constants
  - FSM state encoding (3-bit localparams)
  - TAMANHO_MEM_INST=256
- One natural sub-module, acumulador_checksum:
  - 8-bit modular accumulator with clear and enable
  - a combinational zero-check output for (soma+entrada)

Test Plan:
1. Assert Reset mid-run -> all outputs at reset values, ResetProcessador=1, EntradaPronta=0.
2. Iniciar, then stream 0x02, 0x11, 0x22, 0x33, 0x9A back-to-back:
   - three one-cycle writes: (0x00,0x11), (0x01,0x22), (0x02,0x33)
   - then Concluido=1, ResetProcessador=0
3. Same frame with checksum 0x9B -> ErroChecksum=1, ResetProcessador=1, Concluido=0. A following Iniciar clears ErroChecksum and enters CABECALHO.
4. Same frame as case 2 with EntradaValida toggling every other cycle and Iniciar pulsed during CARGA:
   - identical writes and result
   - no write on invalid cycles
   - Iniciar ignored
5. Header 0xFF, payload bytes 0x00..0xFF, checksum 0x80:
   - 256 writes, last at address 0xFF, no wrap
   - Concluido=1
6. Reset asserted after the second payload byte of case 2 -> state OCIOSO, no further EscritaMemInst. Then from EXECUTA, Iniciar -> ResetProcessador=1 on the next edge and a new load proceeds.

Source files
------------

// File: rtl/nrisc_pkg.sv
// Shared constants and FSM encoding for the nRisc boot path.
// Holds the stream/instruction widths, instruction memory depth and loader states.
// The loader and its checksum accumulator import everything from here.
package nrisc_pkg;

    localparam int LARGURA_DADO     = 8;
    localparam int LARGURA_END      = 8;
    localparam int TAMANHO_MEM_INST = 256;

    // 3-bit state encoding of the program loader
    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        CABECALHO = 3'd1,
        CARGA     = 3'd2,
        CHECKSUM  = 3'd3,
        EXECUTA   = 3'd4,
        ERRO      = 3'd5
    } estado_t;

    // True for the states that consume stream bytes (the load window)
    function automatic logic estado_carregando(input estado_t e);
        return (e == CABECALHO) || (e == CARGA) || (e == CHECKSUM);
    endfunction

endpackage

// File: rtl/carregador_programa_acumulador.sv
// Modulo-256 running sum of the payload bytes, with clear and enable.
// Sum updates one cycle after an enabled byte; zero-check is combinational.
// No backpressure: the caller decides when a byte counts.
module acumulador_checksum
    import nrisc_pkg::*;
(
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_limpa,
    input  logic                    i_habilita,
    input  logic [LARGURA_DADO-1:0] i_entrada,
    output logic                    o_soma_zero
);

    logic [LARGURA_DADO-1:0] r_soma;
    logic [LARGURA_DADO-1:0] w_soma_prox;

    // Wraparound is the intended modulo-256 behaviour
    assign w_soma_prox = r_soma + i_entrada;

    // Frame is good when the trailing byte brings the sum back to zero
    assign o_soma_zero = (w_soma_prox == '0);

    // Accumulator register: clear wins over enable so a new frame always starts at 0
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_soma <= '0;
        end else if (i_limpa) begin
            r_soma <= '0;
        end else if (i_habilita) begin
            r_soma <= w_soma_prox;
        end
    end

endmodule

// File: rtl/carregador_programa.sv
// Boot loader: streams a header/payload/checksum frame into instruction memory, then releases the core.
// Memory write strobe appears 1 cycle after the accepting handshake; status outputs are registered.
// EntradaPronta is decoded from state only; bytes are taken back-to-back while in the load window.
module carregador_programa
    import nrisc_pkg::*;
(
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_iniciar,
    input  logic                    i_entrada_valida,
    input  logic [LARGURA_DADO-1:0] i_entrada_dado,
    output logic                    o_entrada_pronta,
    output logic                    o_escrita_mem_inst,
    output logic [LARGURA_END-1:0]  o_end_mem_inst,
    output logic [LARGURA_DADO-1:0] o_dado_mem_inst,
    output logic                    o_reset_processador,
    output logic                    o_carregando,
    output logic                    o_concluido,
    output logic                    o_erro_checksum
);

    localparam logic [LARGURA_DADO-1:0] UM_DADO = 1;
    localparam logic [LARGURA_END-1:0]  UM_END  = 1;

    estado_t r_estado;
    estado_t w_estado_prox;

    logic [LARGURA_DADO-1:0] r_restantes;
    logic [LARGURA_END-1:0]  r_endereco;

    logic                    r_escrita;
    logic [LARGURA_END-1:0]  r_end_mem;
    logic [LARGURA_DADO-1:0] r_dado_mem;
    logic                    r_reset_proc;
    logic                    r_carregando;
    logic                    r_concluido;
    logic                    r_erro;

    logic w_pronta;
    logic w_transf;
    logic w_limpa_soma;
    logic w_habilita_soma;
    logic w_soma_zero;

    // Ready depends only on state so the source never sees a combinational loop through valid
    assign w_pronta         = estado_carregando(r_estado);
    assign w_transf         = w_pronta & i_entrada_valida;
    assign w_limpa_soma     = w_transf && (r_estado == CABECALHO);
    assign w_habilita_soma  = w_transf && (r_estado == CARGA);

    acumulador_checksum u_acumulador (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_limpa     (w_limpa_soma),
        .i_habilita  (w_habilita_soma),
        .i_entrada   (i_entrada_dado),
        .o_soma_zero (w_soma_zero)
    );

    // State register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_estado_prox;
        end
    end

    // Next-state decode; Iniciar only matters outside the load window
    always_comb begin
        w_estado_prox = r_estado;
        case (r_estado)
            OCIOSO: begin
                if (i_iniciar) begin
                    w_estado_prox = CABECALHO;
                end
            end
            CABECALHO: begin
                if (w_transf) begin
                    w_estado_prox = CARGA;
                end
            end
            CARGA: begin
                if (w_transf && (r_restantes == '0)) begin
                    w_estado_prox = CHECKSUM;
                end
            end
            CHECKSUM: begin
                if (w_transf) begin
                    w_estado_prox = w_soma_zero ? EXECUTA : ERRO;
                end
            end
            EXECUTA: begin
                if (i_iniciar) begin
                    w_estado_prox = CABECALHO;
                end
            end
            ERRO: begin
                if (i_iniciar) begin
                    w_estado_prox = CABECALHO;
                end
            end
            default: begin
                w_estado_prox = OCIOSO;
            end
        endcase
    end

    // Byte counter and write address: header loads the count, each payload byte steps both
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_restantes <= '0;
            r_endereco  <= '0;
        end else if (w_transf && (r_estado == CABECALHO)) begin
            r_restantes <= i_entrada_dado;
            r_endereco  <= '0;
        end else if (w_transf && (r_estado == CARGA) && (r_restantes != '0)) begin
            // Address stops advancing on the last byte, so a 256-byte frame never wraps
            r_restantes <= r_restantes - UM_DADO;
            r_endereco  <= r_endereco + UM_END;
        end
    end

    // Instruction memory port: one-cycle strobe per accepted payload byte, address/data held between writes
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_escrita  <= 1'b0;
            r_end_mem  <= '0;
            r_dado_mem <= '0;
        end else begin
            r_escrita <= 1'b0;
            if (w_transf && (r_estado == CARGA)) begin
                r_escrita  <= 1'b1;
                r_end_mem  <= r_endereco;
                r_dado_mem <= i_entrada_dado;
            end
        end
    end

    // Status flags follow the state being entered, so they change on the same edge as the transition
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_reset_proc <= 1'b1;
            r_carregando <= 1'b0;
            r_concluido  <= 1'b0;
            r_erro       <= 1'b0;
        end else begin
            r_reset_proc <= (w_estado_prox != EXECUTA);
            r_carregando <= estado_carregando(w_estado_prox);
            r_concluido  <= (w_estado_prox == EXECUTA);
            r_erro       <= (w_estado_prox == ERRO);
        end
    end

    assign o_entrada_pronta    = w_pronta;
    assign o_escrita_mem_inst  = r_escrita;
    assign o_end_mem_inst      = r_end_mem;
    assign o_dado_mem_inst     = r_dado_mem;
    assign o_reset_processador = r_reset_proc;
    assign o_carregando        = r_carregando;
    assign o_concluido         = r_concluido;
    assign o_erro_checksum     = r_erro;

endmodule

// File: tb/tb_carregador_programa.sv
// Scoreboard bench for the program loader: expected memory writes are queued at stimulus time
// and a negedge monitor pops and compares every write strobe (address, data, cycle).
// Status outputs are compared directly against hand-computed values after each frame.
module tb_carregador_programa;

    logic       clk;
    logic       rst;
    logic       iniciar;
    logic       valida;
    logic [7:0] dado;
    logic       pronta;
    logic       escrita;
    logic [7:0] end_mem;
    logic [7:0] dado_mem;
    logic       reset_proc;
    logic       carregando;
    logic       concluido;
    logic       erro;

    carregador_programa dut (
        .i_clock             (clk),
        .i_reset             (rst),
        .i_iniciar           (iniciar),
        .i_entrada_valida    (valida),
        .i_entrada_dado      (dado),
        .o_entrada_pronta    (pronta),
        .o_escrita_mem_inst  (escrita),
        .o_end_mem_inst      (end_mem),
        .o_dado_mem_inst     (dado_mem),
        .o_reset_processador (reset_proc),
        .o_carregando        (carregando),
        .o_concluido         (concluido),
        .o_erro_checksum     (erro)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         c;
    } esperado_t;

    esperado_t  fila[$];
    int         total_cnt = 0;
    int         pass_cnt  = 0;
    int         cyc       = 0;
    logic [7:0] pl[256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esp);
        total_cnt++;
        if (atual === esp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nome, atual, esp, $time);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (escrita === 1'b1) begin
            if (fila.size() == 0) begin
                chk("unexpected_write", escrita, 0);
            end else begin
                esperado_t e;
                e = fila.pop_front();
                chk("write_addr", end_mem, e.a);
                chk("write_data", dado_mem, e.d);
                chk("write_cycle", cyc, e.c);
            end
        end
    end

    // Present one byte until accepted; optionally queue the memory write it should produce
    task automatic send(input logic [7:0] b, input bit grava, input logic [7:0] a);
        int n;
        esperado_t e;
        valida = 1'b1;
        dado   = b;
        n      = 0;
        while (!pronta && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!pronta) chk("ready_timeout", pronta, 1);
        @(posedge clk); #1;
        valida = 1'b0;
        if (grava) begin
            e.a = a;
            e.d = b;
            e.c = cyc;
            fila.push_back(e);
        end
    endtask

    task automatic pulso_iniciar();
        iniciar = 1'b1;
        @(posedge clk); #1;
        iniciar = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Whole frame: header, n payload bytes from pl[], checksum; optional one-cycle gaps and an Iniciar pulse in one gap
    task automatic frame(input bit start, input logic [7:0] h, input int n, input logic [7:0] cs,
                         input bit gaps, input bit pulso);
        if (start) pulso_iniciar();
        send(h, 0, 8'h00);
        for (int i = 0; i < n; i++) begin
            send(pl[i], 1, 8'(i));
            if (gaps) begin
                if (pulso && i == 1) iniciar = 1'b1;
                idle(1);
                iniciar = 1'b0;
            end
        end
        send(cs, 0, 8'h00);
    endtask

    task automatic chk_status(input string nome, input logic ep, input logic rp, input logic ca,
                              input logic co, input logic er);
        chk({nome, "_pronta"}, pronta, ep);
        chk({nome, "_reset_proc"}, reset_proc, rp);
        chk({nome, "_carregando"}, carregando, ca);
        chk({nome, "_concluido"}, concluido, co);
        chk({nome, "_erro"}, erro, er);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        iniciar = 1'b0;
        valida  = 1'b0;
        dado    = 8'h00;
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        idle(3);

        // Reset values
        chk_status("reset", 0, 1, 0, 0, 0);
        chk("reset_escrita", escrita, 0);
        chk("reset_end", end_mem, 0);
        chk("reset_dado", dado_mem, 0);
        rst = 1'b0;
        idle(2);

        // Case 1: reset asserted in the middle of a load
        pulso_iniciar();
        send(8'h02, 0, 8'h00);
        send(8'h11, 1, 8'h00);
        idle(1);
        rst = 1'b1; #1;
        chk_status("midreset", 0, 1, 0, 0, 0);
        chk("midreset_escrita", escrita, 0);
        idle(2);
        rst = 1'b0;
        idle(1);

        // Case 2: good frame back-to-back (0x11+0x22+0x33+0x9A = 0x100)
        frame(1, 8'h02, 3, 8'h9A, 0, 0);
        chk_status("good", 0, 0, 0, 1, 0);
        chk("good_drain", fila.size(), 0);
        idle(2);

        // Case 3: bad checksum, then restart clears the error
        frame(1, 8'h02, 3, 8'h9B, 0, 0);
        chk_status("bad", 0, 1, 0, 0, 1);
        chk("bad_drain", fila.size(), 0);
        idle(2);
        pulso_iniciar();
        chk_status("restart_err", 1, 1, 1, 0, 0);

        // Case 4: already in CABECALHO; valid toggling and an ignored Iniciar during CARGA
        frame(0, 8'h02, 3, 8'h9A, 1, 1);
        chk_status("gaps", 0, 0, 0, 1, 0);
        chk("gaps_drain", fila.size(), 0);
        idle(2);

        // Case 5: maximal frame, 256 bytes 0x00..0xFF (sum 0x80, checksum 0x80)
        for (int i = 0; i < 256; i++) pl[i] = 8'(i);
        frame(1, 8'hFF, 256, 8'h80, 0, 0);
        chk_status("max", 0, 0, 0, 1, 0);
        chk("max_drain", fila.size(), 0);
        chk("max_last_addr", end_mem, 8'hFF);
        idle(2);

        // Case 6: reset right after the 2nd payload byte; that byte's pending strobe must vanish
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        pulso_iniciar();
        send(8'h02, 0, 8'h00);
        send(8'h11, 1, 8'h00);
        send(8'h22, 0, 8'h01);
        rst = 1'b1; #1;
        chk_status("r6", 0, 1, 0, 0, 0);
        chk("r6_escrita", escrita, 0);
        idle(3);
        rst = 1'b0;
        idle(2);
        chk("r6_drain", fila.size(), 0);

        frame(1, 8'h02, 3, 8'h9A, 0, 0);
        chk_status("r6_good", 0, 0, 0, 1, 0);
        idle(2);
        pulso_iniciar();
        chk_status("reload_start", 1, 1, 1, 0, 0);
        frame(0, 8'h02, 3, 8'h9A, 0, 0);
        chk_status("reload_done", 0, 0, 0, 1, 0);
        idle(2);
        chk("final_drain", fila.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
